// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronised RxD, mid-bit sampling, byte out with valid/ack handshake.
// Stop-bit errors pulse frame_err; a byte landing on an unacknowledged one pulses overrun.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned CNT_W        = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned    HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       data_out_n;
    logic             data_valid_n, frame_err_n, overrun_n;
    logic             rx_meta, rx_s;

    // Two-flop synchroniser; idle-high reset value avoids a false start after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            frame_err  <= frame_err_n;
            overrun    <= overrun_n;
            busy       <= (state_n != IDLE);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt + CNT_W'(1);
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        data_out_n   = data_out;
        data_valid_n = data_valid & ~data_ack;
        frame_err_n  = 1'b0;
        overrun_n    = 1'b0;

        unique case (state)
            IDLE: begin
                baud_cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_n = '0;
                    shreg_n    = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so the next start edge is caught immediately
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_n = '0;
                    state_n    = IDLE;
                    if (rx_s) begin
                        data_out_n   = shreg;
                        data_valid_n = 1'b1;
                        overrun_n    = data_valid & ~data_ack;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: scoreboarded bytes,
// pulse counters for frame_err/overrun/busy, handshake and reset scenarios.
module tb_uart_receiver;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .RxD        (RxD),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    int cyc = 0, start_cyc = 0, valid_rise_cyc = 0;
    int fe_rises = 0, fe_hi = 0, ov_rises = 0, ov_hi = 0;
    int busy_rises = 0, busy_hi = 0, valid_falls = 0;
    logic p_fe = 1'b0, p_ov = 1'b0, p_busy = 1'b0, p_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_hi++;
            if (frame_err && !p_fe) fe_rises++;
            if (overrun) ov_hi++;
            if (overrun && !p_ov) ov_rises++;
            if (busy) busy_hi++;
            if (busy && !p_busy) busy_rises++;
            if (data_valid && !p_valid) valid_rise_cyc = cyc;
            if (!data_valid && p_valid) valid_falls++;
        end
        p_fe = frame_err; p_ov = overrun; p_busy = busy; p_valid = data_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit push);
        if (push) exp_q.push_back(b);
        start_cyc = cyc;
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(data_out), 32'(e));
            check({tag, "_valid"}, 32'(data_valid), 32'd1);
        end
    endtask

    task automatic ack_byte(input string tag);
        check({tag, "_valid_before_ack"}, 32'(data_valid), 32'd1);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        check({tag, "_valid_after_ack"}, 32'(data_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int fe0, ov0, vf0, br0, bh0;
        reset = 1'b1; RxD = 1'b1; data_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte, latency and busy duration
        bh0 = busy_hi;
        send_frame(8'h55, 1'b1, 1'b1);
        pop_check("b55");
        check("b55_latency_ok", 32'((valid_rise_cyc - start_cyc) >= 154 && (valid_rise_cyc - start_cyc) <= 156), 32'd1);
        check("b55_busy_len_ok", 32'((busy_hi - bh0) >= 150 && (busy_hi - bh0) <= 156), 32'd1);
        repeat (3) @(negedge clk);
        ack_byte("b55");
        check("b55_no_frame_err", 32'(fe_rises), 32'd0);
        check("b55_no_overrun", 32'(ov_rises), 32'd0);

        // Short glitch on the line: rejected at the half-bit check
        br0 = busy_rises;
        RxD = 1'b0; repeat (4) @(negedge clk);
        RxD = 1'b1; repeat (30) @(negedge clk);
        check("glitch_busy_rose", 32'(busy_rises - br0), 32'd1);
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_valid", 32'(data_valid), 32'd0);
        check("glitch_data", 32'(data_out), 32'h55);
        check("glitch_no_fe", 32'(fe_rises), 32'd0);

        // Framing error
        fe0 = fe_hi;
        send_frame(8'hA3, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("fe_pulses", 32'(fe_rises), 32'd1);
        check("fe_width", 32'(fe_hi - fe0), 32'd1);
        check("fe_valid", 32'(data_valid), 32'd0);
        check("fe_data_kept", 32'(data_out), 32'h55);

        // Back-to-back, no ack: overrun
        vf0 = valid_falls; ov0 = ov_rises;
        send_frame(8'h12, 1'b1, 1'b1);
        pop_check("b2b_12");
        send_frame(8'h34, 1'b1, 1'b1);
        pop_check("b2b_34");
        check("b2b_overrun_once", 32'(ov_rises - ov0), 32'd1);
        check("b2b_overrun_width", 32'(ov_hi), 32'd1);
        check("b2b_valid_held", 32'(valid_falls - vf0), 32'd0);
        ack_byte("b2b");

        // Back-to-back with ack coinciding with the second completion
        send_frame(8'h12, 1'b1, 1'b1);
        pop_check("coin_12");
        vf0 = valid_falls; ov0 = ov_rises;
        fork
            send_frame(8'h34, 1'b1, 1'b1);
            begin
                repeat (154) @(negedge clk);
                data_ack = 1'b1;
                @(negedge clk);
                data_ack = 1'b0;
            end
        join
        pop_check("coin_34");
        check("coin_no_overrun", 32'(ov_rises - ov0), 32'd0);
        check("coin_valid_held", 32'(valid_falls - vf0), 32'd0);
        ack_byte("coin");

        // Reset in the middle of a 0xFF frame
        RxD = 1'b0; repeat (CPB) @(negedge clk);
        RxD = 1'b1; repeat (40) @(negedge clk);
        pulse_reset();
        check("midrst_data_out", 32'(data_out), 32'h0);
        check("midrst_valid", 32'(data_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_fe", 32'(frame_err), 32'd0);
        repeat (200) @(negedge clk);
        check("midrst_no_spurious", 32'(data_valid), 32'd0);
        fe0 = fe_rises; ov0 = ov_rises;
        send_frame(8'h0F, 1'b1, 1'b1);
        pop_check("after_rst_0f");
        check("after_rst_no_fe", 32'(fe_rises - fe0), 32'd0);
        check("after_rst_no_ov", 32'(ov_rises - ov0), 32'd0);
        ack_byte("after_rst");

        // Break: line held low, one frame error per frame period
        fe0 = fe_rises;
        RxD = 1'b0;
        repeat (480) @(negedge clk);
        check("break_fe_count", 32'(fe_rises - fe0), 32'd3);
        check("break_fe_single_cycle", 32'(fe_hi), 32'(fe_rises));
        check("break_valid", 32'(data_valid), 32'd0);
        RxD = 1'b1;
        pulse_reset();
        repeat (10) @(negedge clk);
        fe0 = fe_rises;
        send_frame(8'hC6, 1'b1, 1'b1);
        pop_check("post_break_c6");
        check("post_break_no_fe", 32'(fe_rises - fe0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART serial receiver: 8N1 frames in on RxD (idle high, LSB first, 1 start, 8 data, 1 stop) → parallel byte out with valid/ack handshake.
- Downstream counterpart of the team's uart transmitter; same baud divisor convention (clock cycles per bit).
- Feeds the command/data parser on the FPGA side.
- Default divisor 10416 = 100 MHz / 9600 baud.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per serial bit; must be ≥ 8. HALF_BIT = CLKS_PER_BIT/2, truncated.
- CNT_W, 14, baud counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- RxD  in  1  asynchronous serial input, idle high.
- data_out  out  8  last correctly framed byte.
- data_valid  out  1  high while data_out holds an unacknowledged byte.
- data_ack  in  1  consumer takes data_out; sampled each cycle.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while data_valid=1 and no ack that cycle.
- busy  out  1  high whenever FSM ≠ IDLE.

Behaviour:
Input synchronisation:
- RxD passes through a 2-flop synchroniser (rx_s); both flops reset to 1. All decisions use rx_s only.

Reset values (reset=1 at a rising edge):
- state=IDLE, baud_cnt=0, bit_idx=0, shift register=0.
- data_out=0x00, data_valid=0, frame_err=0, overrun=0, busy=0.
- Reset overrides everything, including mid-frame. The partial byte is discarded and no pulse is produced.

FSM (baud_cnt increments every cycle outside IDLE and clears on every state change or sample):
- IDLE: rx_s=0 → START, baud_cnt=0.
- START: at baud_cnt = HALF_BIT−1, check rx_s.
  - rx_s=0: valid start; → DATA, baud_cnt=0, bit_idx=0.
  - rx_s=1: glitch; → IDLE, no outputs change.
- DATA: at baud_cnt = CLKS_PER_BIT−1, sample rx_s into shreg[7] with a right shift (LSB first), baud_cnt=0.
  - bit_idx=7 → STOP; otherwise bit_idx+1.
  - Samples therefore land at the mid-point of each bit.
- STOP: at baud_cnt = CLKS_PER_BIT−1, sample the stop bit, then → IDLE. Returning to IDLE at mid-stop-bit allows the next start edge to be caught immediately.
  - rx_s=1: data_out ← shreg; data_valid=1 from the next cycle.
  - rx_s=0: frame_err=1 for exactly one cycle; data_out and data_valid unchanged.
- busy = (state ≠ IDLE), registered with the state.

Handshake:
- data_valid clears on the cycle after data_ack=1 is sampled while data_valid=1.
- data_ack while data_valid=0 is ignored.
- Byte completes and data_ack=1 in the same cycle: new byte loaded, data_valid stays 1, no overrun.
- Byte completes while data_valid=1 and data_ack=0: data_out overwritten with the new byte, data_valid stays 1, overrun pulses for one cycle.

Latency:
- From RxD falling edge to data_valid rising: 2 + HALF_BIT + 9·CLKS_PER_BIT + 1 cycles, ±1.

Boundary conditions:
- RxD held low permanently (break): frame_err pulses once per frame period.
- No lock-up; the FSM re-enters START whenever rx_s=0 in IDLE.

Test Plan:
All scenarios use CLKS_PER_BIT=16 unless stated.
- Send 0x55, ack 3 cycles after valid → data_out=0x55; data_valid high from its rising edge until the cycle after ack; frame_err=0, overrun=0; busy high for about 9.5 bit times.
- RxD low pulse of 4 cycles, then high → busy rises then falls at the half-bit check; data_valid, frame_err and data_out unchanged.
- Frame 0xA3 with stop bit forced 0 → frame_err pulses exactly 1 cycle; data_valid stays 0; data_out keeps its prior value.
- Back-to-back 0x12 then 0x34, no ack → data_out=0x34, overrun one-cycle pulse at the second completion, data_valid=1 throughout. Repeat with ack coinciding with the second completion → no overrun.
- Assert reset for 1 cycle mid-DATA of 0xFF, then send 0x0F → all outputs zero after reset; no spurious byte; 0x0F received correctly.
- Loopback with the team's uart transmitter, both at CLKS_PER_BIT=10416 and 100 MHz, sending 0x00, 0xA3, 0xFF → each byte received intact, no frame_err or overrun; latency within the stated bound.
